upsampling_2x2: RTL and testbench
=================================

Name: upsampling_2x2

Overview:
- 2x2 nearest-neighbour upsampler; the inverse-direction counterpart of the 2x2 max-pooling stage in the VGG16 datapath.
- Accepts a raster-order stream of a pooled feature map, IN_WIDTH x IN_HEIGHT.
- Emits a (2*IN_WIDTH) x (2*IN_HEIGHT) raster stream: each pixel repeated twice horizontally, each row repeated twice vertically.
- Buffers one input row internally. Uses valid/ready handshakes on both sides so it can sit between convolution/pooling stages with backpressure.

Parameters:
- DATA_WIDTH, 32, pixel word width in bits (raw bits, no arithmetic performed).
- IN_WIDTH, 3, input row length in pixels; must be >= 1.
- IN_HEIGHT, 3, input rows per frame; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- i_data  input  DATA_WIDTH  input pixel.
- valid_in  input  1  i_data is valid this cycle.
- ready_in  output  1  block accepts i_data this cycle. Transfer occurs when valid_in && ready_in.
- o_data  output  DATA_WIDTH  output pixel.
- valid_out  output  1  o_data is valid this cycle.
- ready_out  input  1  downstream accepts o_data. Transfer occurs when valid_out && ready_out.
- frame_done  output  1  one-cycle pulse, asserted the cycle after the last output beat of a frame transfers.

Behaviour:
- Reset is synchronous, active-high, one clock, single clock domain.
- State after reset: FILL; wr_col=0, out_col=0, dup=0, row_cnt=0.
- Output values after reset: ready_in=1, valid_out=0, o_data=0, frame_done=0. Line buffer contents are don't-care.
- States: FILL, EMIT_A, EMIT_B.
- FILL:
  - ready_in=1, valid_out=0.
  - On each input transfer: buf[wr_col] <= i_data; wr_col increments.
  - On the transfer with wr_col==IN_WIDTH-1: wr_col <= 0, state <= EMIT_A.
  - Cycles with valid_in=0 hold all state.
- EMIT_A and EMIT_B:
  - ready_in=0. valid_in is ignored; no write occurs.
  - valid_out=1. o_data = buf[out_col], driven from registered state only (no combinational path from i_data or ready_out).
  - On each output transfer, dup toggles. When dup was 1, out_col increments. Sequence per row pass: buf[0],buf[0],buf[1],buf[1],...; 2*IN_WIDTH beats total.
  - ready_out=0: o_data, valid_out and all counters hold (stable under backpressure).
  - Last beat of EMIT_A (out_col==IN_WIDTH-1, dup==1) transfers: out_col <= 0, dup <= 0, state <= EMIT_B. This replays the same row.
  - Last beat of EMIT_B transfers: state <= FILL.
    - If row_cnt==IN_HEIGHT-1: row_cnt <= 0 and frame_done=1 on the next cycle.
    - Otherwise row_cnt increments.
- o_data is forced to 0 whenever valid_out=0.
- Latency: first output beat is valid the cycle after the last input pixel of a row transfers.
- Throughput:
  - Per input row: IN_WIDTH input cycles (minimum) plus 4*IN_WIDTH output cycles; no overlap between fill and emit.
  - Minimum frame time with no stalls: 5*IN_WIDTH*IN_HEIGHT cycles.
- Boundaries:
  - IN_WIDTH=1: each row emits 2 beats per pass.
  - IN_HEIGHT=1: frame_done after the first row's EMIT_B.
  - Back-to-back frames: FILL for the next frame starts in the same cycle frame_done is asserted. No idle gap is required.
  - Reset asserted mid-FILL or mid-EMIT: the partial row is discarded. Outputs return to reset values on the next edge. No output beat or frame_done pulse follows from the aborted frame.
  - rst and valid_in asserted together: reset wins; the pixel is not stored.
- Counter widths: wr_col and out_col use clog2(IN_WIDTH) bits (min 1); row_cnt uses clog2(IN_HEIGHT) bits (min 1). No wrap beyond the terminal count.

Test Plan:
- Basic frame, IN_WIDTH=3, IN_HEIGHT=3: input 1..9, valid_in held high, ready_out=1.
  - Output row 0 = 1,1,2,2,3,3; row 1 = 1,1,2,2,3,3; row 2 = 4,4,5,5,6,6; and so on: 36 beats total.
  - frame_done pulses once, the cycle after beat 36.
  - Total 45 cycles from first input to frame_done.
- Backpressure: toggle ready_out 1,0,0,1,... pseudo-randomly.
  - Same 36-value sequence.
  - o_data/valid_out unchanged across every ready_out=0 cycle; no beat duplicated or dropped.
- Input gaps: valid_in low for 2 cycles between each pixel.
  - Output sequence identical to the basic frame.
  - First output beat appears exactly 1 cycle after pixel 3 transfers.
- Valid during emit: hold valid_in=1 with i_data=0xDEAD throughout EMIT_A/EMIT_B.
  - ready_in=0 during those states.
  - 0xDEAD never appears in the output; the next row's FILL captures the first value presented while in FILL.
- Reset mid-operation: assert rst for 1 cycle during the 5th beat of EMIT_B on row 1.
  - Next cycle: ready_in=1, valid_out=0, o_data=0, frame_done=0.
  - A fresh frame 10..18 then produces the correct 36-beat output with no residue from row 1.
- Back-to-back frames plus corner parameters: two consecutive frames with no gap.
  - Two frame_done pulses, 45 cycles apart.
  - Repeat with IN_WIDTH=1, IN_HEIGHT=1: input 7 -> output 7,7,7,7, frame_done after the 4th beat.

Source files
------------

// File: rtl/upsampling_2x2.sv
// 2x2 nearest-neighbour upsampler: buffers one input row, then replays it twice
// with every pixel doubled, giving a (2*IN_WIDTH) x (2*IN_HEIGHT) raster stream.
module upsampling_2x2 #(
   parameter int DATA_WIDTH = 32,
   parameter int IN_WIDTH   = 3,
   parameter int IN_HEIGHT  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  valid_in,
   output logic                  ready_in,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  valid_out,
   input  logic                  ready_out,
   output logic                  frame_done
);
   localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
   localparam int RW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
   localparam logic [CW-1:0] LAST_COL = CW'(IN_WIDTH - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IN_HEIGHT - 1);

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      EMIT_A = 2'd1,
      EMIT_B = 2'd2
   } state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_line [IN_WIDTH];
   logic [CW-1:0]         r_wr_col;
   logic [CW-1:0]         r_out_col;
   logic                  r_dup;
   logic [RW-1:0]         r_row_cnt;
   logic                  r_frame_done;

   logic w_fill;
   logic w_in_xfer;
   logic w_wr_last;
   logic w_beat_last;

   assign w_fill      = (r_state == FILL);
   assign w_in_xfer   = valid_in && w_fill;
   assign w_wr_last   = (r_wr_col == LAST_COL);
   assign w_beat_last = r_dup && (r_out_col == LAST_COL);

   assign ready_in   = w_fill;
   assign valid_out  = !w_fill;
   // Output is a pure function of registers, so it stays stable under backpressure.
   assign o_data     = w_fill ? '0 : r_line[r_out_col];
   assign frame_done = r_frame_done;

   // Line buffer has no reset; a write during reset is suppressed so reset wins.
   always_ff @(posedge clk) begin
      if (!rst && w_in_xfer) begin
         r_line[r_wr_col] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= FILL;
         r_wr_col     <= '0;
         r_out_col    <= '0;
         r_dup        <= 1'b0;
         r_row_cnt    <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            FILL: begin
               if (valid_in) begin
                  if (w_wr_last) begin
                     r_wr_col <= '0;
                     r_state  <= EMIT_A;
                  end else begin
                     r_wr_col <= r_wr_col + 1'b1;
                  end
               end
            end
            EMIT_A, EMIT_B: begin
               if (ready_out) begin
                  r_dup <= ~r_dup;
                  if (r_dup) begin
                     r_out_col <= r_out_col + 1'b1;
                  end
                  if (w_beat_last) begin
                     r_out_col <= '0;
                     r_dup     <= 1'b0;
                     if (r_state == EMIT_A) begin
                        r_state <= EMIT_B;
                     end else begin
                        r_state <= FILL;
                        if (r_row_cnt == LAST_ROW) begin
                           r_row_cnt    <= '0;
                           r_frame_done <= 1'b1;
                        end else begin
                           r_row_cnt <= r_row_cnt + 1'b1;
                        end
                     end
                  end
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_upsampling_2x2.sv
// Directed bench for upsampling_2x2: a 3x3 instance for the main scenarios and a
// 1x1 instance for the degenerate-size corner.
module tb_upsampling_2x2;
   localparam int DW = 32;
   localparam logic [31:0] DEAD = 32'hDEAD;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [DW-1:0] i_data;
   logic          valid_in;
   logic          ready_in;
   logic [DW-1:0] o_data;
   logic          valid_out;
   logic          ready_out;
   logic          frame_done;

   logic [DW-1:0] i_data_b;
   logic          valid_in_b;
   logic          ready_in_b;
   logic [DW-1:0] o_data_b;
   logic          valid_out_b;
   logic          ready_out_b;
   logic          frame_done_b;

   upsampling_2x2 #(.DATA_WIDTH(DW), .IN_WIDTH(3), .IN_HEIGHT(3)) u_dut (
      .clk(clk), .rst(rst), .i_data(i_data), .valid_in(valid_in), .ready_in(ready_in),
      .o_data(o_data), .valid_out(valid_out), .ready_out(ready_out), .frame_done(frame_done)
   );

   upsampling_2x2 #(.DATA_WIDTH(DW), .IN_WIDTH(1), .IN_HEIGHT(1)) u_dut_b (
      .clk(clk), .rst(rst), .i_data(i_data_b), .valid_in(valid_in_b), .ready_in(ready_in_b),
      .o_data(o_data_b), .valid_out(valid_out_b), .ready_out(ready_out_b), .frame_done(frame_done_b)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit bp_en = 1'b0;

   logic [31:0] got_q[$];
   int          fd_q[$];
   int          in_cnt, first_in, in3_cyc, first_out;
   logic        pv, pr;
   logic [31:0] pd;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      got_q.delete();
      fd_q.delete();
      in_cnt = 0; first_in = -1; in3_cyc = -1; first_out = -1;
   endtask

   // Downstream ready: constant 1, or a pseudo-random pattern when backpressure is on.
   initial begin
      ready_out = 1'b1;
      forever begin
         @(posedge clk); #1;
         ready_out = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: samples mid-cycle, records transfers and checks hold/idle rules.
   always @(negedge clk) begin
      if (rst) begin
         pv = 1'b0;
      end else begin
         if (valid_in && ready_in) begin
            in_cnt++;
            if (first_in < 0) first_in = cyc;
            if (in_cnt == 3) in3_cyc = cyc;
         end
         if (valid_out && ready_out) begin
            if (first_out < 0) first_out = cyc;
            got_q.push_back(o_data);
            $display("beat %0d data=%0h cyc=%0d", got_q.size(), o_data, cyc);
         end
         if (frame_done) fd_q.push_back(cyc);
         if (pv && !pr) begin
            chk("hold_valid", valid_out, 1);
            chk("hold_data", o_data, pd);
         end
         if (valid_out) chk("rdy_in_emit", ready_in, 0);
         else chk("idle_zero", o_data, 0);
         pv = valid_out; pr = ready_out; pd = o_data;
      end
   end

   function automatic logic [31:0] exp_val(input int base, input int k);
      int kk, fr, row, c;
      kk  = k % 36;
      fr  = k / 36;
      row = kk / 12;
      c   = (kk % 6) / 2;
      return 32'(base + fr * 9 + row * 3 + c);
   endfunction

   task automatic check_seq(input string tag, input int base, input int n);
      chk({tag, "_beats"}, got_q.size(), n);
      for (int k = 0; k < n && k < got_q.size(); k++)
         chk($sformatf("%s_beat%0d", tag, k), got_q[k], exp_val(base, k));
   endtask

   // Presents pixels base..base+n-1; in dead mode 0xDEAD is offered while not ready.
   task automatic send_pixels(input int base, input int n, input int gap, input bit dead);
      for (int p = 0; p < n; p++) begin
         bit done;
         int t;
         if (p > 0) repeat (gap) begin valid_in = 1'b0; @(posedge clk); #1; end
         done = 1'b0;
         t = 0;
         while (!done && t < 400) begin
            valid_in = 1'b1;
            i_data   = (dead && !ready_in) ? DEAD : 32'(base + p);
            @(negedge clk);
            done = ready_in;
            @(posedge clk); #1;
            t++;
         end
         if (!done) chk("in_timeout", 0, 1);
      end
      valid_in = 1'b0;
      i_data   = '0;
   endtask

   task automatic wait_fd(input int n);
      int t = 0;
      while (fd_q.size() < n && t < 800) begin @(posedge clk); #1; t++; end
      chk("fd_wait", 32'(fd_q.size() >= n), 1);
      repeat (8) begin @(posedge clk); #1; end
   endtask

   initial begin
      rst = 1'b1; valid_in = 1'b1; i_data = 32'h55;
      valid_in_b = 1'b0; i_data_b = '0; ready_out_b = 1'b1;
      clr();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready_in", ready_in, 1);
      chk("rst_valid_out", valid_out, 0);
      chk("rst_o_data", o_data, 0);
      chk("rst_frame_done", frame_done, 0);
      rst = 1'b0; valid_in = 1'b0;
      clr();

      // Basic frame
      send_pixels(1, 9, 0, 0);
      wait_fd(1);
      chk("basic_fd_cnt", fd_q.size(), 1);
      if (fd_q.size() > 0) chk("basic_frame_cycles", fd_q[0] - first_in, 45);
      chk("basic_latency", first_out - in3_cyc, 1);
      check_seq("basic", 1, 36);

      // Backpressure
      clr(); bp_en = 1'b1;
      send_pixels(1, 9, 0, 0);
      wait_fd(1);
      bp_en = 1'b0;
      chk("bp_fd_cnt", fd_q.size(), 1);
      check_seq("bp", 1, 36);

      // Input gaps
      clr();
      send_pixels(1, 9, 2, 0);
      wait_fd(1);
      chk("gap_latency", first_out - in3_cyc, 1);
      check_seq("gap", 1, 36);

      // Valid held with junk during emit
      clr();
      send_pixels(1, 9, 0, 1);
      wait_fd(1);
      check_seq("dead", 1, 36);

      // Reset during 5th beat of row 1 EMIT_B (overall beat 23)
      clr();
      send_pixels(1, 6, 0, 0);
      begin
         int t = 0;
         while (got_q.size() < 22 && t < 400) begin @(posedge clk); #1; t++; end
         chk("mid_wait", got_q.size(), 22);
      end
      chk("mid_beat23_valid", valid_out, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_ready_in", ready_in, 1);
      chk("mid_valid_out", valid_out, 0);
      chk("mid_o_data", o_data, 0);
      chk("mid_frame_done", frame_done, 0);
      rst = 1'b0;
      clr();
      send_pixels(10, 9, 0, 0);
      wait_fd(1);
      chk("mid_fd_cnt", fd_q.size(), 1);
      check_seq("mid", 10, 36);

      // Back-to-back frames
      clr();
      send_pixels(1, 18, 0, 0);
      wait_fd(2);
      chk("b2b_fd_cnt", fd_q.size(), 2);
      if (fd_q.size() > 1) chk("b2b_fd_gap", fd_q[1] - fd_q[0], 45);
      check_seq("b2b", 1, 72);

      // 1x1 instance: 7 -> 7,7,7,7 then frame_done
      valid_in_b = 1'b1; i_data_b = 32'd7;
      chk("b_ready_in", ready_in_b, 1);
      @(posedge clk); #1;
      valid_in_b = 1'b0; i_data_b = '0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("b_valid%0d", i), valid_out_b, 1);
         chk($sformatf("b_data%0d", i), o_data_b, 7);
         chk($sformatf("b_fd_early%0d", i), frame_done_b, 0);
         $display("beat_b %0d data=%0h", i + 1, o_data_b);
         @(posedge clk); #1;
      end
      chk("b_fd", frame_done_b, 1);
      chk("b_idle_valid", valid_out_b, 0);
      chk("b_idle_data", o_data_b, 0);
      @(posedge clk); #1;
      chk("b_fd_pulse", frame_done_b, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
